// File: rtl/fpga_pll_pkg.sv
// fpga_pll_pkg: sequencer states, default timing constants and a saturating status-counter helper
package fpga_pll_pkg;
  typedef enum logic [2:0] {HOLD, WAIT_LOCK, STABLE, RUN, FAIL} pll_seq_state_t;
  localparam int RST_HOLD_CYC_DEF = 200;
  localparam int LOCK_TIMEOUT_CYC_DEF = 20000;
  localparam int STABLE_CYC_DEF = 1024;
  localparam int MAX_RETRY_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int STAT_W = 8;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/fpga_pll_rst_seq_if.sv
// fpga_pll_rst_seq_if: PLL control and status bundle; master = sequencer, slave = PLL/consumer side
interface fpga_pll_rst_seq_if;
  import fpga_pll_pkg::*;
  logic pll_locked_i;
  logic pll_rst_n_o;
  logic ready_o;
  logic fail_o;
  logic [STAT_W-1:0] retry_cnt_o;
  logic [STAT_W-1:0] loss_cnt_o;
  modport master (input pll_locked_i, output pll_rst_n_o, ready_o, fail_o, retry_cnt_o, loss_cnt_o);
  modport slave (output pll_locked_i, input pll_rst_n_o, ready_o, fail_o, retry_cnt_o, loss_cnt_o);
endinterface

// File: rtl/fpga_sync_2ff.sv
// fpga_sync_2ff: two-flop synchronizer for a single asynchronous level
module fpga_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/fpga_pll_rst_seq.sv
// fpga_pll_rst_seq: PLL reset/lock sequencer with timeout retry and lock-stability qualification
// Optional `PLL_RETRY_LIMIT_EN: enter terminal FAIL after MAX_RETRY consecutive timeouts.
module fpga_pll_rst_seq
  import fpga_pll_pkg::*;
#(
  parameter int RST_HOLD_CYC = RST_HOLD_CYC_DEF,
  parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  fpga_pll_rst_seq_if.master bus
);
`ifdef PLL_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_END = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STAB_END = CNT_W'(STABLE_CYC - 1);
  localparam logic [STAT_W-1:0] RETRY_LIM = STAT_W'(MAX_RETRY);
  pll_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [STAT_W-1:0] retry_q, retry_d, loss_q, loss_d;
  logic lock_s;
  fpga_sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(bus.pll_locked_i), .q(lock_s));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= HOLD;
      timer_q <= '0;
      retry_q <= '0;
      loss_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      loss_q <= loss_d;
    end
  // Every state transition restarts the shared timer from zero.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    retry_d = retry_q;
    loss_d = loss_q;
    case (state_q)
      HOLD:
        if (timer_q == HOLD_END) state_d = WAIT_LOCK;
        else timer_d = timer_q + 1'b1;
      WAIT_LOCK:
        if (lock_s) state_d = STABLE;
        else if (timer_q == TO_END) begin
          retry_d = sat_inc(retry_q);
          state_d = (LIMIT_EN && retry_d >= RETRY_LIM) ? FAIL : HOLD;
        end else timer_d = timer_q + 1'b1;
      STABLE:
        if (!lock_s) state_d = WAIT_LOCK;
        else if (timer_q == STAB_END) begin
          state_d = RUN;
          retry_d = '0;
        end else timer_d = timer_q + 1'b1;
      RUN:
        if (!lock_s) begin
          state_d = HOLD;
          loss_d = sat_inc(loss_q);
        end
      default: state_d = state_q;
    endcase
  end
  assign bus.pll_rst_n_o = !(state_q inside {HOLD, FAIL});
  assign bus.ready_o = state_q == RUN;
  assign bus.fail_o = state_q == FAIL;
  assign bus.retry_cnt_o = retry_q;
  assign bus.loss_cnt_o = loss_q;
endmodule
